// File: rtl/cmd_pkg.sv
// Shared definitions for the command issuer: command encoding, issuer
// states and the result checksum fold.
package cmd_pkg;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ADD = 3'd1;
    localparam logic [2:0] CMD_SUB = 3'd2;
    localparam logic [2:0] CMD_AND = 3'd3;
    localparam logic [2:0] CMD_OR  = 3'd4;
    localparam logic [2:0] CMD_XOR = 3'd5;
    localparam logic [2:0] CMD_SHL = 3'd6;
    localparam logic [2:0] CMD_SHR = 3'd7;

    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] op1;
        logic [7:0] op2;
    } cmd_t;

    localparam cmd_t CMD_IDLE_WORD = '{kind: CMD_NOP, op1: 4'd0, op2: 8'd0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic logic [7:0] checksum_fold(input logic [7:0] sum, input logic [3:0] res);
        return {sum[6:0], sum[7]} ^ {4'b0000, res};
    endfunction

endpackage

// File: rtl/cmd_prog_mem.sv
// Program store for the command issuer: synchronous write, combinational read.
module cmd_prog_mem
    import cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  cmd_t          wdata_i,
    input  logic [AW-1:0] raddr_i,
    output cmd_t          rdata_o
);

    cmd_t mem_q [DEPTH];

    // Program entries are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cmd_issuer.sv
// Replays a stored command program to the core loop_count times and folds the
// core results into a checksum. Optional NOP gaps: define CMD_ISSUER_GAP_EN.
module cmd_issuer
    import cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [14:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic [7:0]    loop_count,
    input  logic          start,
`ifdef CMD_ISSUER_GAP_EN
    input  logic [3:0]    gap,
`endif
    output logic [2:0]    command_kind,
    output logic [3:0]    command_operand1,
    output logic [7:0]    command_operand2,
    input  logic [3:0]    result_in,
    output logic          busy,
    output logic          done,
    output logic [7:0]    checksum
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    pass_q, pass_d;
    logic [AW:0]   len_q, len_d;
    logic [7:0]    loops_q, loops_d;
    cmd_t          cmd_q, cmd_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    sum_q, sum_d;
`ifdef CMD_ISSUER_GAP_EN
    logic [3:0]    gap_q, gap_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic          gap_last_q, gap_last_d;
`endif

    cmd_t          wdata_s;
    cmd_t          rd_s;
    logic          last_pc_s;
    logic          last_pass_s;
    logic          accept_s;

    assign wdata_s = cmd_t'(prog_data);

    cmd_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (wdata_s),
        .raddr_i (pc_q),
        .rdata_o (rd_s)
    );

    assign last_pc_s   = ({1'b0, pc_q} == (len_q - ONE_L));
    assign last_pass_s = (pass_q == (loops_q - 8'd1));
    // busy_q stays high through the cycle after DRAIN, which blocks a restart there.
    assign accept_s    = start && !busy_q && (state_q == ST_IDLE);

    // Next-state, run bookkeeping and checksum update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pass_d     = pass_q;
        len_d      = len_q;
        loops_d    = loops_q;
        done_d     = 1'b0;
        sum_d      = valid_q ? checksum_fold(sum_q, result_in) : sum_q;
`ifdef CMD_ISSUER_GAP_EN
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        gap_last_d = gap_last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (prog_len != {(AW+1){1'b0}})) begin
                    state_d = ST_ISSUE;
                    pc_d    = {AW{1'b0}};
                    pass_d  = 8'd0;
                    len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                    loops_d = (loop_count == 8'd0) ? 8'd1 : loop_count;
                    sum_d   = 8'd0;
`ifdef CMD_ISSUER_GAP_EN
                    gap_d      = gap;
                    gap_cnt_d  = 4'd0;
                    gap_last_d = 1'b0;
`endif
                end else begin
                    // Either an empty-program start or the first idle cycle after a run.
                    done_d = busy_q || accept_s;
                end
            end
            ST_ISSUE: begin
                pc_d   = last_pc_s ? {AW{1'b0}} : (pc_q + AW'(1'b1));
                pass_d = last_pc_s ? (pass_q + 8'd1) : pass_q;
`ifdef CMD_ISSUER_GAP_EN
                if (gap_q != 4'd0) begin
                    state_d    = ST_GAP;
                    gap_cnt_d  = gap_q;
                    gap_last_d = last_pc_s && last_pass_s;
                end else if (last_pc_s && last_pass_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
`else
                if (last_pc_s && last_pass_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
`endif
            end
`ifdef CMD_ISSUER_GAP_EN
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q == 4'd1) begin
                    state_d = gap_last_q ? ST_DRAIN : ST_ISSUE;
                end else begin
                    state_d = ST_GAP;
                end
            end
`endif
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage: every core-facing signal is registered one cycle behind the state.
    always_comb begin
        cmd_d   = (state_q == ST_ISSUE) ? rd_s : CMD_IDLE_WORD;
        valid_d = (state_q == ST_ISSUE);
        busy_d  = (state_q != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= {AW{1'b0}};
            pass_q     <= 8'd0;
            len_q      <= {(AW+1){1'b0}};
            loops_q    <= 8'd0;
            cmd_q      <= CMD_IDLE_WORD;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= 8'd0;
`ifdef CMD_ISSUER_GAP_EN
            gap_q      <= 4'd0;
            gap_cnt_q  <= 4'd0;
            gap_last_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pass_q     <= pass_d;
            len_q      <= len_d;
            loops_q    <= loops_d;
            cmd_q      <= cmd_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sum_q      <= sum_d;
`ifdef CMD_ISSUER_GAP_EN
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            gap_last_q <= gap_last_d;
`endif
        end
    end

    assign command_kind     = cmd_q.kind;
    assign command_operand1 = cmd_q.op1;
    assign command_operand2 = cmd_q.op2;
    assign busy             = busy_q;
    assign done             = done_q;
    assign checksum         = sum_q;

endmodule

// File: tb/tb_cmd_issuer.sv
// Bench for cmd_issuer: directed table of runs, corner sequences and random
// runs, all checked against a replay model of the program and result fold.
`timescale 1ns/1ps
module tb_cmd_issuer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [14:0]   prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic [7:0]    loop_count = '0;
    logic          start = 1'b0;
    logic [2:0]    command_kind;
    logic [3:0]    command_operand1;
    logic [7:0]    command_operand2;
    logic [3:0]    result_in = '0;
    logic          busy;
    logic          done;
    logic [7:0]    checksum;
`ifdef CMD_ISSUER_GAP_EN
    logic [3:0]    gap = 4'd0;
`endif

    logic [14:0] prog_m [DEPTH];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int plen;
        int loops;
        int exp_busy;
        int wr_t;
        bit poke;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    cmd_issuer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .prog_we          (prog_we),
        .prog_addr        (prog_addr),
        .prog_data        (prog_data),
        .prog_len         (prog_len),
        .loop_count       (loop_count),
        .start            (start),
`ifdef CMD_ISSUER_GAP_EN
        .gap              (gap),
`endif
        .command_kind     (command_kind),
        .command_operand1 (command_operand1),
        .command_operand2 (command_operand2),
        .result_in        (result_in),
        .busy             (busy),
        .done             (done),
        .checksum         (checksum)
    );

    function automatic logic [7:0] fold_m(input logic [7:0] c, input logic [3:0] r);
        logic [7:0] rot;
        rot = 8'((c << 1) | (c >> 7));
        return rot ^ 8'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int a, input logic [14:0] d);
        prog_we   = 1'b1;
        prog_addr = a[AW-1:0];
        prog_data = d;
        @(posedge clk); #1;
        prog_we   = 1'b0;
        prog_m[a] = d;
    endtask

    // Start a run and check every cycle against the replayed program.
    task automatic run_prog(input int plen, input int ploops, input int exp_busy,
                            input bit fixed_r, input int wr_t, input bit poke);
        int len_e, loops_e, n, busy_cnt, wa;
        logic [7:0]  sum_m;
        logic [3:0]  r_cur;
        logic [14:0] exp_w, new_w;
        len_e    = (plen > DEPTH) ? DEPTH : plen;
        loops_e  = (ploops == 0) ? 1 : ploops;
        n        = len_e * loops_e;
        busy_cnt = 0;
        sum_m    = 8'd0;
        wa       = 0;
        new_w    = 15'($urandom);
        prog_len   = plen[AW:0];
        loop_count = ploops[7:0];
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy) busy_cnt++;
        if (len_e == 0) begin
            chk("zero_len_done", done, 1);
            chk("zero_len_cmd", {command_kind, command_operand1, command_operand2}, 0);
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            chk("zero_len_done_clear", done, 0);
            chk("zero_len_cmd2", {command_kind, command_operand1, command_operand2}, 0);
            chk("zero_len_busy_cycles", busy_cnt, exp_busy);
            return;
        end
        chk("busy_after_start", busy, 0);
        r_cur = fixed_r ? 4'hA : 4'($urandom);
        result_in = r_cur;
        for (int t = 1; t <= n + 3; t++) begin
            @(posedge clk);
            if (t >= 2 && t - 1 <= n) sum_m = fold_m(sum_m, r_cur);
            #1;
            exp_w = (t <= n) ? prog_m[(t - 1) % len_e] : 15'd0;
            chk("cmd", {command_kind, command_operand1, command_operand2}, exp_w);
            if (busy) busy_cnt++;
            chk("busy", busy, (t <= n + 1) ? 1 : 0);
            chk("done", done, (t == n + 2) ? 1 : 0);
            if (t == n + 2) chk("checksum", checksum, sum_m);
            if (poke && t == 1) begin
                start    = 1'b1;
                prog_len = 4'($urandom);
            end
            if (poke && t == 2) start = 1'b0;
            if (wr_t >= 2 && t == wr_t - 1) begin
                wa        = (wr_t - 1) % len_e;
                prog_we   = 1'b1;
                prog_addr = wa[AW-1:0];
                prog_data = new_w;
            end
            if (wr_t >= 2 && t == wr_t) begin
                prog_we    = 1'b0;
                prog_m[wa] = new_w;
            end
            r_cur = fixed_r ? 4'hA : 4'($urandom);
            result_in = r_cur;
        end
        start = 1'b0;
        chk("busy_cycles", busy_cnt, exp_busy);
    endtask

    initial begin
        int plen, ploops, len_e, n, wr_t;
        logic [7:0] sum_m;

        vecs[0] = '{3, 2, 7, 0, 0};
        vecs[1] = '{1, 1, 2, 0, 1};
        vecs[2] = '{8, 1, 9, 5, 0};
        vecs[3] = '{12, 1, 9, 0, 0};
        vecs[4] = '{4, 0, 5, 0, 1};
        vecs[5] = '{0, 3, 0, 0, 0};
        vecs[6] = '{2, 3, 7, 3, 1};
        vecs[7] = '{1, 255, 256, 0, 0};
        vecs[8] = '{15, 2, 17, 10, 0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_cmd", {command_kind, command_operand1, command_operand2}, 0);
            chk("idle_busy", busy, 0);
            chk("idle_checksum", checksum, 0);
            chk("idle_done", done, 0);
        end

        load(0, {3'd1, 4'd2, 8'h10});
        load(1, {3'd2, 4'd3, 8'h20});
        load(2, {3'd3, 4'd4, 8'h30});
        run_prog(3, 2, 7, 1'b0, 0, 1'b0);

        for (int a = 0; a < 4; a++) load(a, 15'($urandom));
        run_prog(4, 1, 5, 1'b1, 0, 1'b0);

        for (int a = 0; a < DEPTH; a++) load(a, 15'($urandom));
        for (int v = 0; v < 9; v++) begin
            run_prog(vecs[v].plen, vecs[v].loops, vecs[v].exp_busy, 1'b0, vecs[v].wr_t, vecs[v].poke);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset on the third issue cycle, then replay from entry 0.
        prog_len = 4'd3; loop_count = 8'd2; result_in = 4'hA; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_cmd0", {command_kind, command_operand1, command_operand2}, prog_m[0]);
        @(posedge clk); #1;
        chk("pre_reset_sum", checksum, fold_m(8'd0, 4'hA));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_cmd", {command_kind, command_operand1, command_operand2}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        run_prog(3, 2, 7, 1'b0, 0, 1'b0);

`ifdef CMD_ISSUER_GAP_EN
        begin
            int pat [7];
            logic [3:0] r_cur;
            pat = '{0, -1, -1, 1, -1, -1, -1};
            load(0, {3'd5, 4'd1, 8'h11});
            load(1, {3'd6, 4'd2, 8'h22});
            gap = 4'd2; prog_len = 4'd2; loop_count = 8'd1; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            sum_m = 8'd0;
            r_cur = 4'($urandom);
            result_in = r_cur;
            for (int t = 1; t <= 8; t++) begin
                @(posedge clk);
                if (t >= 2 && pat[t - 2] >= 0) sum_m = fold_m(sum_m, r_cur);
                #1;
                if (t <= 7) begin
                    chk("gap_cmd", {command_kind, command_operand1, command_operand2},
                        (pat[t - 1] >= 0) ? prog_m[pat[t - 1]] : 15'd0);
                    chk("gap_busy", busy, 1);
                    chk("gap_done", done, 0);
                end else begin
                    chk("gap_done_end", done, 1);
                    chk("gap_busy_end", busy, 0);
                    chk("gap_checksum", checksum, sum_m);
                end
                r_cur = 4'($urandom);
                result_in = r_cur;
            end
            gap = 4'd0;
        end
`endif

        for (int it = 0; it < 12; it++) begin
            for (int a = 0; a < DEPTH; a++) load(a, 15'($urandom));
            plen   = $urandom_range(0, 12);
            ploops = $urandom_range(0, 4);
            len_e  = (plen > DEPTH) ? DEPTH : plen;
            n      = len_e * ((ploops == 0) ? 1 : ploops);
            wr_t   = (n >= 2) ? $urandom_range(2, n) : 0;
            run_prog(plen, ploops, (len_e == 0) ? 0 : n + 1, 1'b0, wr_t, 1'($urandom));
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
